sram_like_slave: RTL and testbench

- Responder end of the sram-like data bus driven by the MEM stage (req/wr/size/addr/wdata → addr_ok/data_ok/rdata).
- Serves requests from an internal word-organised memory with programmable address and data wait states.
- Used as the data-side memory model in core-level simulation and as a small on-chip scratch RAM; one outstanding transaction at a time.

---
 rtl/sram_like_slave_if.sv | 28 ++
 rtl/sram_like_slave.sv | 179 +++++++++++++++++
 tb/tb_sram_like_slave.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_slave_if.sv
// sram-like data bus between the MEM stage (master) and a memory responder.
// Request side: req/wr/size/addr/wdata/uncached; response side: addr_ok/data_ok/rdata/err.
interface sram_like_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_uncached;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        err_misaligned;

  modport master (
    output data_req, data_wr, data_size,
    output data_addr, data_wdata, data_uncached,
    input  data_addr_ok, data_data_ok,
    input  data_rdata, err_misaligned
  );

  modport slave (
    input  data_req, data_wr, data_size,
    input  data_addr, data_wdata, data_uncached,
    output data_addr_ok, data_data_ok,
    output data_rdata, err_misaligned
  );
endinterface

// File: rtl/sram_like_slave.sv
// Word-organised sram-like responder with programmable address/data waits.
// Define SRAM_SLAVE_RANDOM_WAIT_EN to add 0..3 LFSR-driven extra data wait cycles.
module sram_like_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int ADDR_WAIT  = 0,
  parameter int DATA_WAIT  = 1
) (
  input  logic clk,
  input  logic resetn,
  sram_like_slave_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = 16;

  typedef enum logic [1:0] {
    IDLE,
    AWAIT,
    DWAIT
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          wr_q, wr_d;
  logic          ill_q, ill_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic                  legal;
  logic                  addr_ok;
  logic                  accept;
  logic                  we;
  logic                  data_ok;
  logic [1:0]            extra;

  logic unused_bits;
  assign unused_bits = ^{bus.data_uncached,
                         bus.data_addr[31:ADDR_WIDTH+2]};

  assign idx = bus.data_addr[ADDR_WIDTH+1:2];

`ifdef SRAM_SLAVE_RANDOM_WAIT_EN
  logic [7:0] lfsr_q, lfsr_d;

  // x^8+x^6+x^5+x^4+1, free-running
  always_comb begin
    lfsr_d = {lfsr_q[6:0],
              lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign extra = lfsr_q[1:0];
`else
  assign extra = 2'd0;
`endif

  always_comb begin
    legal = 1'b0;
    be    = 4'b0000;
    unique case (1'b1)
      (bus.data_size == 2'd0): begin
        legal = 1'b1;
        be    = 4'b0001 << bus.data_addr[1:0];
      end
      (bus.data_size == 2'd1): begin
        legal = !bus.data_addr[0];
        be    = bus.data_addr[1] ? 4'b1100 : 4'b0011;
      end
      (bus.data_size == 2'd2): begin
        legal = (bus.data_addr[1:0] == 2'b00);
        be    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
        be    = 4'b0000;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    wr_d    = wr_q;
    ill_d   = ill_q;
    rdata_d = rdata_q;
    addr_ok = 1'b0;
    accept  = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_ok = (ADDR_WAIT == 0) && bus.data_req;
        if (bus.data_req && !addr_ok) begin
          state_d = AWAIT;
          cnt_d   = CW'(ADDR_WAIT - 1);
        end
      end
      AWAIT: begin
        addr_ok = (cnt_q == '0) && bus.data_req;
        if (!bus.data_req) begin
          state_d = IDLE;
        end else if (!addr_ok) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DWAIT: begin
        if (dcnt_q == '0) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = addr_ok && bus.data_req;

    // writes and illegal requests complete with a zero word
    if (accept) begin
      state_d = DWAIT;
      dcnt_d  = CW'(DATA_WAIT - 1) + CW'(extra);
      wr_d    = bus.data_wr;
      ill_d   = !legal;
      rdata_d = (legal && !bus.data_wr) ? mem[idx] : 32'h0;
    end
  end

  assign we = accept && bus.data_wr && legal;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][i*8 +: 8] <= bus.data_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      wr_q    <= 1'b0;
      ill_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      wr_q    <= wr_d;
      ill_q   <= ill_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_ok = (state_q == DWAIT) && (dcnt_q == '0);

  assign bus.data_addr_ok   = addr_ok;
  assign bus.data_data_ok   = data_ok;
  assign bus.data_rdata     = data_ok ? rdata_q : 32'h0;
  assign bus.err_misaligned = data_ok && ill_q;

endmodule

// File: tb/tb_sram_like_slave.sv
// Randomised scoreboard bench for sram_like_slave: default instance plus
// an ADDR_WAIT=2 / DATA_WAIT=3 instance, checked against a byte-lane model.
module tb_sram_like_slave;

  localparam int AW = 10;
`ifdef SRAM_SLAVE_RANDOM_WAIT_EN
  localparam int XTRA = 3;
`else
  localparam int XTRA = 0;
`endif

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  logic sel, req, wr, unc;
  logic [1:0] size;
  logic [31:0] addr, wdata;
  logic aok;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] refm0 [16];
  logic [31:0] refm1 [16];
  logic [31:0] last_rd [2];
  logic last_err [2];

  sram_like_slave_if ifa ();
  sram_like_slave_if ifb ();

  sram_like_slave #(.ADDR_WIDTH(AW)) dut_a (
    .clk(clk), .resetn(rst_a), .bus(ifa.slave)
  );

  sram_like_slave #(
    .ADDR_WIDTH(AW), .ADDR_WAIT(2), .DATA_WAIT(3)
  ) dut_b (
    .clk(clk), .resetn(rst_b), .bus(ifb.slave)
  );

  assign ifa.data_req      = req && !sel;
  assign ifa.data_wr       = wr;
  assign ifa.data_size     = size;
  assign ifa.data_addr     = addr;
  assign ifa.data_wdata    = wdata;
  assign ifa.data_uncached = unc;
  assign ifb.data_req      = req && sel;
  assign ifb.data_wr       = wr;
  assign ifb.data_size     = size;
  assign ifb.data_addr     = addr;
  assign ifb.data_wdata    = wdata;
  assign ifb.data_uncached = unc;
  assign aok = sel ? ifb.data_addr_ok : ifa.data_addr_ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: byte lanes covered by the access, legality from size/offset
  function automatic void model(input int d, input logic w,
                                input logic [1:0] sz,
                                input logic [31:0] a,
                                input logic [31:0] wd,
                                output logic [31:0] rd,
                                output logic err);
    int ix, off, n;
    logic ok;
    logic [31:0] word;
    ix = int'(a[5:2]);
    off = int'(a[1:0]);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    ok = (sz != 2'd3) && ((off % n) == 0);
    word = (d == 1) ? refm1[ix] : refm0[ix];
    rd = 32'h0;
    err = !ok;
    if (ok && w) begin
      for (int i = 0; i < n; i++) begin
        word[(off+i)*8 +: 8] = wd[(off+i)*8 +: 8];
      end
      if (d == 1) refm1[ix] = word;
      else refm0[ix] = word;
    end else if (ok) begin
      rd = word;
    end
  endfunction

  task automatic mon(input int d, input logic ok,
                     input logic [31:0] rd, input logic err);
    exp_t e;
    int lat, dw;
    dw = (d == 1) ? 3 : 1;
    if (!ok) begin
      chk("idle_rdata", rd, 32'h0);
      chk("idle_err", {31'h0, err}, 32'h0);
      return;
    end
    if ((d == 1 ? q1.size() : q0.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_data_ok dut%0d: got 1, required 0", d);
      return;
    end
    if (d == 1) e = q1.pop_front();
    else e = q0.pop_front();
    lat = cyc - e.acc + 1;
    chk("rdata", rd, e.rd);
    chk("err_misaligned", {31'h0, err}, {31'h0, e.err});
    checks++;
    if (lat < dw || lat > dw + XTRA) begin
      errors++;
      $display("FAIL latency dut%0d: got %0d, required %0d..%0d",
               d, lat, dw, dw + XTRA);
    end
    last_rd[d] = rd;
    last_err[d] = err;
  endtask

  always @(negedge clk) begin
    mon(0, ifa.data_data_ok, ifa.data_rdata, ifa.err_misaligned);
    mon(1, ifb.data_data_ok, ifb.data_rdata, ifb.err_misaligned);
  end

  task automatic drain();
    int k;
    k = 0;
    while ((q0.size() + q1.size()) != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if ((q0.size() + q1.size()) != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0",
               q0.size() + q1.size());
    end
  endtask

  task automatic issue(input int d, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       input bit push);
    exp_t e;
    int n;
    bit got;
    drain();
    n = 0;
    got = 1'b0;
    sel = (d == 1);
    wr = w;
    size = sz;
    addr = a;
    wdata = wd;
    unc = 1'($urandom);
    req = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (aok) got = 1'b1;
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    chk("addr_wait", n, (d == 1) ? 3 : 1);
    if (!got) return;
    model(d, w, sz, a, wd, e.rd, e.err);
    e.acc = cyc;
    if (push) begin
      if (d == 1) q1.push_back(e);
      else q0.push_back(e);
    end
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom & 32'hFFFF_F000;
    a[5:0] = 6'($urandom_range(0, 63));
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; req = 1'b0; wr = 1'b0; unc = 1'b0;
    size = 2'd0; addr = 32'h0; wdata = 32'h0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr_ok", {31'h0, ifa.data_addr_ok}, 32'h0);
    chk("rst_data_ok", {31'h0, ifa.data_data_ok}, 32'h0);
    chk("rst_rdata", ifa.data_rdata, 32'h0);
    chk("rst_err", {31'h0, ifa.err_misaligned}, 32'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, 2'd2, 32'(i * 4), $urandom, 1'b1);
      issue(1, 1'b1, 2'd2, 32'(i * 4), $urandom, 1'b1);
    end

    issue(0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, 1'b1);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1);
    drain();
    chk("word_rd", last_rd[0], 32'hDEADBEEF);

    issue(0, 1'b1, 2'd0, 32'h13, 32'h5A5A5A5A, 1'b1);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1);
    drain();
    chk("byte_merge", last_rd[0], 32'h5AADBEEF);

    issue(0, 1'b0, 2'd1, 32'h11, 32'h0, 1'b1);
    drain();
    chk("half_odd_rd", last_rd[0], 32'h0);
    chk("half_odd_err", {31'h0, last_err[0]}, 32'h1);
    issue(0, 1'b1, 2'd3, 32'h10, 32'h11223344, 1'b1);
    drain();
    chk("size3_err", {31'h0, last_err[0]}, 32'h1);
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1);
    drain();
    chk("no_change", last_rd[0], 32'h5AADBEEF);

    // abandoned request on the waited instance
    drain();
    sel = 1'b1; wr = 1'b1; size = 2'd2;
    addr = 32'h14; wdata = ~refm1[5]; req = 1'b1;
    @(negedge clk);
    chk("abandon_aok", {31'h0, ifb.data_addr_ok}, 32'h0);
    @(posedge clk);
    #1;
    req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    issue(1, 1'b0, 2'd2, 32'h14, 32'h0, 1'b1);
    drain();
    chk("abandon_mem", last_rd[1], refm1[5]);

    // reset in the data_ok cycle of a read
    issue(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b0);
    repeat (2 + XTRA) @(posedge clk);
    #1;
    if (XTRA == 0) chk("pre_rst_dok", {31'h0, ifb.data_data_ok}, 32'h1);
    rst_b = 1'b0;
    #1;
    chk("rst_b_aok", {31'h0, ifb.data_addr_ok}, 32'h0);
    chk("rst_b_dok", {31'h0, ifb.data_data_ok}, 32'h0);
    chk("rst_b_rdata", ifb.data_rdata, 32'h0);
    chk("rst_b_err", {31'h0, ifb.err_misaligned}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    issue(1, 1'b0, 2'd2, 32'h20, 32'h0, 1'b1);
    drain();
    chk("post_rst_mem", last_rd[1], refm1[8]);

    for (int t = 0; t < 1000; t++) begin
      issue(0, 1'($urandom), 2'($urandom), rnd_addr(), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
    for (int t = 0; t < 200; t++) begin
      issue(1, 1'($urandom), 2'($urandom), rnd_addr(), $urandom, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
